// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline register: a DEPTH-entry in-order circular buffer between
// two valid/ready stages, with a flush that squashes every in-flight entry.
module pipe_elastic_stage #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;
  logic             squash;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1. in_ready and out_valid come only from the registered count, so
  // neither side ever sees a combinational path from the other side's ready.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign squash    = reset | flush;
  assign count     = count_q;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (squash) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is left unreset; out_data masks any unwritten entry to zero.
  always_ff @(posedge clk) begin
    if (!squash && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Bench for pipe_elastic_stage: a DEPTH=2 instance for directed vectors and a
// DEPTH=3 instance for a randomised wrap-around stream, both scoreboarded.
module tb_pipe_elastic_stage;

  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;

  logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [W-1:0] a_in_data, a_out_data;
  logic [1:0]   a_count;

  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [W-1:0] b_in_data, b_out_data;
  logic [1:0]   b_count;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];

  int checks = 0;
  int errors = 0;
  int rx_b = 0;
  int max_b = 0;

  logic         a_push = 1'b0, a_clr = 1'b0;
  logic         b_push = 1'b0, b_clr = 1'b0;
  logic [W-1:0] a_push_data = '0, b_push_data = '0;

  always #5 clk = ~clk;

  pipe_elastic_stage #(.WIDTH(W), .DEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  pipe_elastic_stage #(.WIDTH(W), .DEPTH(3)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare on each transfer, then note what the next edge accepts.
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready && !reset && !a_flush) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_output: got 0x%0h expected no entry", a_out_data);
      end else begin
        chk("a_out_order", a_out_data, exp_a.pop_front());
      end
    end
    a_push      = a_in_valid && a_in_ready && !reset && !a_flush;
    a_clr       = reset || a_flush;
    a_push_data = a_in_data;
  end

  always @(negedge clk) begin
    if (b_out_valid && b_out_ready && !reset && !b_flush) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_output: got 0x%0h expected no entry", b_out_data);
      end else begin
        chk("b_out_order", b_out_data, exp_b.pop_front());
        rx_b++;
      end
    end
    if (int'(b_count) > max_b) max_b = int'(b_count);
    b_push      = b_in_valid && b_in_ready && !reset && !b_flush;
    b_clr       = reset || b_flush;
    b_push_data = b_in_data;
  end

  always @(posedge clk) begin
    if (a_clr) exp_a.delete();
    else if (a_push) exp_a.push_back(a_push_data);
    if (b_clr) exp_b.delete();
    else if (b_push) exp_b.push_back(b_push_data);
  end

  initial begin
    int word;
    reset = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 64'hDEAD; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b1; b_in_data = 64'hBEEF; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    chk("rst_count", W'(a_count), 0);
    chk("rst_out_valid", W'(a_out_valid), 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_in_ready", W'(a_in_ready), 1);
    chk("rst_b_count", W'(b_count), 0);

    // Stream at full rate
    step(); a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 64'h11;
    @(negedge clk); chk("stream_no_bypass", W'(a_out_valid), 0);
    chk("stream_in_ready0", W'(a_in_ready), 1);
    step(); a_in_data = 64'h22;
    @(negedge clk); chk("stream_out11", a_out_data, 64'h11); chk("stream_count1", W'(a_count), 1);
    step(); a_in_data = 64'h33;
    @(negedge clk); chk("stream_out22", a_out_data, 64'h22); chk("stream_in_ready", W'(a_in_ready), 1);
    step(); a_in_valid = 1'b0;
    @(negedge clk); chk("stream_out33", a_out_data, 64'h33); chk("stream_count2", W'(a_count), 1);
    step();
    @(negedge clk); chk("stream_drained", W'(a_out_valid), 0);

    // Backpressure, then release while full
    step(); a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 64'hA;
    @(negedge clk); chk("bp_ready_a", W'(a_in_ready), 1);
    step(); a_in_data = 64'hB;
    @(negedge clk); chk("bp_count1", W'(a_count), 1);
    step(); a_in_data = 64'hC;
    @(negedge clk); chk("bp_count2", W'(a_count), 2); chk("bp_full_ready", W'(a_in_ready), 0);
    step(); a_out_ready = 1'b1;
    @(negedge clk); chk("bp_full_pop_ready", W'(a_in_ready), 0); chk("bp_head_a", a_out_data, 64'hA);
    step();
    @(negedge clk); chk("bp_after_pop_count", W'(a_count), 1); chk("bp_after_pop_ready", W'(a_in_ready), 1);
    chk("bp_head_b", a_out_data, 64'hB);
    step(); a_in_valid = 1'b0;
    @(negedge clk); chk("bp_head_c", a_out_data, 64'hC); chk("bp_count_c", W'(a_count), 1);
    step();
    @(negedge clk); chk("bp_empty", W'(a_count), 0);

    // Simultaneous push and pop at count=1
    step(); a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 64'h41;
    step(); a_out_ready = 1'b1; a_in_data = 64'h42;
    @(negedge clk); chk("pp_count", W'(a_count), 1); chk("pp_head41", a_out_data, 64'h41);
    step(); a_in_valid = 1'b0;
    @(negedge clk); chk("pp_count_after", W'(a_count), 1); chk("pp_head42", a_out_data, 64'h42);
    step();
    @(negedge clk); chk("pp_empty", W'(a_count), 0);

    // Flush while full with a push pending
    step(); a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 64'h51;
    step(); a_in_data = 64'h52;
    step(); a_in_data = 64'hF; a_flush = 1'b1;
    @(negedge clk); chk("fl_pre_count", W'(a_count), 2);
    step(); a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(negedge clk); chk("fl_count", W'(a_count), 0); chk("fl_out_valid", W'(a_out_valid), 0);
    chk("fl_in_ready", W'(a_in_ready), 1); chk("fl_out_data", a_out_data, 0);
    repeat (3) step();

    // DEPTH=3 random handshake stream of words 0..49
    word = 0;
    for (int cyc = 0; cyc < 3000 && rx_b < 50; cyc++) begin
      @(posedge clk);
      if (b_push) word++;
      #1;
      if (!b_in_valid || b_push) b_in_valid = (word < 50) && ($urandom_range(0, 2) != 0);
      b_in_data   = W'(word);
      b_out_ready = $urandom_range(0, 1) != 0;
    end
    b_in_valid = 1'b0;
    repeat (2) step();
    chk("wrap_received", W'(rx_b), 50);
    chk("wrap_max_count_ok", W'(max_b <= 3), 1);
    chk("wrap_queue_empty", W'(exp_b.size()), 0);
    chk("a_queue_empty", W'(exp_a.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
